// File: rtl/gpio_bus_pkg.sv
// Shared types and constants for the GPIO/ADC decoder bus initiator.
// The decoder needs at least 4 strobe cycles and 3 idle cycles per access.
package gpio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam int MIN_HOLD_CYCLES = 4;
  localparam int MIN_GAP_CYCLES  = 3;
  localparam int SCAN_WORDS      = 3;
  localparam int SCAN_BASE_ADDR  = 'h400;

  function automatic int scan_addr(input int idx);
    return SCAN_BASE_ADDR + idx;
  endfunction

endpackage

// File: rtl/gpio_poll_timer.sv
// Auto-scan request timer: free-running divider while enabled, raising a sticky
// poll_due flag on every wrap; poll_due_next lets the initiator register cmd_ready.
module gpio_poll_timer #(
  parameter int PollDiv = 1000
) (
  input  logic reg_clk,
  input  logic reset_in,
  input  logic poll_enable,
  input  logic clear_due,
  output logic poll_due,
  output logic poll_due_next
);

  localparam int CW = $clog2(PollDiv + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          wrap;

  always_comb begin
    wrap          = poll_enable && (count == CW'(PollDiv - 1));
    count_next    = count + CW'(1);
    poll_due_next = poll_due;
    if (!poll_enable) begin
      count_next    = '0;
      poll_due_next = 1'b0;
    end else if (wrap) begin
      count_next    = '0;
      poll_due_next = 1'b1;
    end else if (clear_due) begin
      poll_due_next = 1'b0;
    end
  end

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      count    <= '0;
      poll_due <= 1'b0;
    end else begin
      count    <= count_next;
      poll_due <= poll_due_next;
    end
  end

endmodule

// File: rtl/gpio_bus_initiator.sv
// Bus master for the GPIO/ADC register decoder: serves host read/write commands
// and periodically scans the three GPIO input words into a snapshot.
module gpio_bus_initiator
  import gpio_bus_pkg::*;
#(
  parameter int AddrWidth  = 16,
  parameter int BusWidth   = 32,
  parameter int HoldCycles = 4,
  parameter int GapCycles  = 3,
  parameter int PollDiv    = 1000
) (
  input  logic                  reg_clk,
  input  logic                  reset_in,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AddrWidth-3:0]  cmd_addr,
  input  logic [BusWidth-1:0]   cmd_wdata,
  output logic                  rsp_valid,
  output logic [BusWidth-1:0]   rsp_rdata,
  input  logic                  poll_enable,
  output logic [3*BusWidth-1:0] in_snap,
  output logic                  snap_valid,
  output logic                  chip_sel,
  output logic                  read_reg,
  output logic                  write_reg,
  output logic [AddrWidth-3:0]  busaddress,
  output logic [BusWidth-1:0]   busdata_in,
  input  logic [BusWidth-1:0]   busdata_out
);

  localparam int AW      = AddrWidth - 2;
  localparam int CNT_MAX = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if (HoldCycles < MIN_HOLD_CYCLES || GapCycles < MIN_GAP_CYCLES || PollDiv < 1) begin : g_bad_params
    $error("gpio_bus_initiator: HoldCycles>=4, GapCycles>=3 and PollDiv>=1 are required");
  end

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  scan_active, scan_active_nxt;
  logic [1:0]            scan_idx, scan_idx_nxt;
  logic [BusWidth-1:0]   stage0, stage0_nxt, stage1, stage1_nxt;
  logic                  chip_sel_nxt, read_nxt, write_nxt, cmd_ready_nxt;
  logic [AW-1:0]         addr_nxt;
  logic [BusWidth-1:0]   wdata_nxt, rsp_rdata_nxt;
  logic                  rsp_valid_nxt, snap_valid_nxt;
  logic [3*BusWidth-1:0] in_snap_nxt;
  logic                  poll_due, poll_due_next, clear_due;

  gpio_poll_timer #(.PollDiv(PollDiv)) u_poll_timer (
    .reg_clk       (reg_clk),
    .reset_in      (reset_in),
    .poll_enable   (poll_enable),
    .clear_due     (clear_due),
    .poll_due      (poll_due),
    .poll_due_next (poll_due_next)
  );

  assign clear_due = (state == ST_IDLE) && !scan_active && poll_due;

  // The GAP state covers GapCycles-1 low cycles; the IDLE arbitration cycle is the last one.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    scan_active_nxt = scan_active;
    scan_idx_nxt    = scan_idx;
    stage0_nxt      = stage0;
    stage1_nxt      = stage1;
    chip_sel_nxt    = chip_sel;
    read_nxt        = read_reg;
    write_nxt       = write_reg;
    addr_nxt        = busaddress;
    wdata_nxt       = busdata_in;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    in_snap_nxt     = in_snap;
    snap_valid_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scan_active || poll_due) begin
          if (!scan_active) begin
            scan_active_nxt = 1'b1;
            scan_idx_nxt    = 2'd0;
          end
          state_nxt    = ST_ACCESS;
          cnt_nxt      = CW'(HoldCycles - 1);
          chip_sel_nxt = 1'b1;
          read_nxt     = 1'b1;
          write_nxt    = 1'b0;
          addr_nxt     = AW'(scan_addr(scan_active ? int'(scan_idx) : 0));
          wdata_nxt    = '0;
        end else if (cmd_valid && cmd_ready) begin
          state_nxt    = ST_ACCESS;
          cnt_nxt      = CW'(HoldCycles - 1);
          chip_sel_nxt = 1'b1;
          read_nxt     = !cmd_write;
          write_nxt    = cmd_write;
          addr_nxt     = cmd_addr;
          wdata_nxt    = cmd_write ? cmd_wdata : '0;
        end
      end
      ST_ACCESS: begin
        if (cnt == '0) begin
          state_nxt    = ST_GAP;
          cnt_nxt      = CW'(GapCycles - 2);
          chip_sel_nxt = 1'b0;
          read_nxt     = 1'b0;
          write_nxt    = 1'b0;
          if (scan_active) begin
            if (scan_idx == 2'd0) begin
              stage0_nxt   = busdata_out;
              scan_idx_nxt = 2'd1;
            end else if (scan_idx == 2'd1) begin
              stage1_nxt   = busdata_out;
              scan_idx_nxt = 2'd2;
            end else begin
              in_snap_nxt     = {busdata_out, stage1, stage0};
              snap_valid_nxt  = 1'b1;
              scan_active_nxt = 1'b0;
              scan_idx_nxt    = 2'd0;
            end
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = write_reg ? '0 : busdata_out;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd_ready_nxt = (state_nxt == ST_IDLE) && !scan_active_nxt && !poll_due_next;

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      scan_active <= 1'b0;
      scan_idx    <= 2'd0;
      stage0      <= '0;
      stage1      <= '0;
      cmd_ready   <= 1'b0;
      chip_sel    <= 1'b0;
      read_reg    <= 1'b0;
      write_reg   <= 1'b0;
      busaddress  <= '0;
      busdata_in  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      in_snap     <= '0;
      snap_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      scan_active <= scan_active_nxt;
      scan_idx    <= scan_idx_nxt;
      stage0      <= stage0_nxt;
      stage1      <= stage1_nxt;
      cmd_ready   <= cmd_ready_nxt;
      chip_sel    <= chip_sel_nxt;
      read_reg    <= read_nxt;
      write_reg   <= write_nxt;
      busaddress  <= addr_nxt;
      busdata_in  <= wdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      in_snap     <= in_snap_nxt;
      snap_valid  <= snap_valid_nxt;
    end
  end

endmodule

// File: tb/tb_gpio_bus_initiator.sv
// Directed bench for gpio_bus_initiator with a behavioural decoder read model
// and scoreboards for command responses and scan snapshots.
module tb_gpio_bus_initiator;

  localparam int AW = 16;
  localparam int BW = 32;
  localparam int PD = 16;

  logic          reg_clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-3:0] cmd_addr = '0;
  logic [BW-1:0] cmd_wdata = '0;
  logic          poll_enable = 1'b0;
  logic          cmd_ready, rsp_valid, snap_valid, chip_sel, read_reg, write_reg;
  logic [BW-1:0] rsp_rdata, busdata_in, busdata_out;
  logic [3*BW-1:0] in_snap;
  logic [AW-3:0] busaddress;

  logic [BW-1:0] rd_val [3];

  int checks = 0;
  int errors = 0;

  logic [BW-1:0]   rsp_q [$];
  logic [3*BW-1:0] snap_q [$];
  int              hi_q [$];
  int              lo_q [$];
  logic [AW-3:0]   addr_q [$];
  logic [BW-1:0]   wd_q [$];
  int rsp_cnt = 0, snap_cnt = 0, wr_cycles = 0, rd_cycles = 0;
  int hi_len = 0, lo_len = 0;
  bit prev_cs = 1'b0, seen = 1'b0;

  always #5 reg_clk = ~reg_clk;

  gpio_bus_initiator #(
    .AddrWidth(AW), .BusWidth(BW), .HoldCycles(4), .GapCycles(3), .PollDiv(PD)
  ) dut (
    .reg_clk(reg_clk), .reset_in(reset_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .poll_enable(poll_enable), .in_snap(in_snap), .snap_valid(snap_valid),
    .chip_sel(chip_sel), .read_reg(read_reg), .write_reg(write_reg),
    .busaddress(busaddress), .busdata_in(busdata_in), .busdata_out(busdata_out)
  );

  // Decoder read model: returns the programmed word for 0x400..0x402.
  always_comb begin
    busdata_out = '0;
    if (chip_sel && read_reg) begin
      case (busaddress)
        14'h400: busdata_out = rd_val[0];
        14'h401: busdata_out = rd_val[1];
        14'h402: busdata_out = rd_val[2];
        default: busdata_out = 32'hDEAD_BEEF;
      endcase
    end
  end

  task automatic check(input string tag, input logic [3*BW-1:0] obs, input logic [3*BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor sampled 1 time unit after each rising edge.
  always begin
    @(posedge reg_clk);
    #1;
    if (reset_in) begin
      prev_cs = 1'b0; seen = 1'b0; hi_len = 0; lo_len = 0;
    end else begin
      if (chip_sel) begin
        if (!prev_cs) begin
          if (seen) lo_q.push_back(lo_len);
          addr_q.push_back(busaddress);
          wd_q.push_back(busdata_in);
        end
        hi_len++; lo_len = 0; seen = 1'b1;
      end else begin
        if (prev_cs) begin
          hi_q.push_back(hi_len);
          hi_len = 0;
        end
        lo_len++;
      end
      prev_cs = chip_sel;
      if (write_reg) wr_cycles++;
      if (read_reg) rd_cycles++;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
        else check("rsp_rdata", rsp_rdata, rsp_q.pop_front());
      end
      if (snap_valid) begin
        snap_cnt++;
        if (snap_q.size() == 0) check("snap_unexpected", snap_valid, 0);
        else check("in_snap", in_snap, snap_q.pop_front());
      end
    end
  end

  task automatic clr();
    hi_q.delete(); lo_q.delete(); addr_q.delete(); wd_q.delete();
    wr_cycles = 0; rd_cycles = 0;
  endtask

  task automatic send_cmd(input logic w, input logic [AW-3:0] a, input logic [BW-1:0] d,
                          input logic [BW-1:0] rexp, input bit hold, output int waited);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge reg_clk);
      waited++;
    end
    check("cmd_accept", cmd_ready, 1);
    rsp_q.push_back(rexp);
    @(negedge reg_clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  initial begin
    int n, r0, s0;
    rd_val[0] = 32'h00A5A5A5; rd_val[1] = 32'h0; rd_val[2] = 32'h0;

    // Reset state
    repeat (3) @(negedge reg_clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_strobes", {chip_sel, read_reg, write_reg}, 0);
    check("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    check("rst_bus", {busaddress, busdata_in}, 0);
    check("rst_snap", {snap_valid, in_snap}, 0);
    reset_in = 1'b0;
    @(negedge reg_clk);
    check("ready_after_rst", cmd_ready, 1);

    // Single write
    clr();
    send_cmd(1'b1, 14'h440, 32'h00FFFFFF, 32'h0, 1'b0, n);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge reg_clk); n++; end
    check("ready_period", n + 1, 7);
    repeat (2) @(negedge reg_clk);
    check("wr_write_cycles", wr_cycles, 4);
    check("wr_read_cycles", rd_cycles, 0);
    check("wr_hold", hi_q[0], 4);
    check("wr_addr", addr_q[0], 14'h440);
    check("wr_data", wd_q[0], 32'h00FFFFFF);
    check("wr_rsp_cnt", rsp_cnt, 1);

    // Single read
    clr();
    send_cmd(1'b0, 14'h400, 32'h12345678, 32'h00A5A5A5, 1'b0, n);
    repeat (9) @(negedge reg_clk);
    check("rd_read_cycles", rd_cycles, 4);
    check("rd_write_cycles", wr_cycles, 0);
    check("rd_busdata_in", wd_q[0], 0);
    check("rd_rsp_cnt", rsp_cnt, 2);

    // Auto-scan
    clr();
    rd_val[0] = 32'h11; rd_val[1] = 32'h22; rd_val[2] = 32'h33;
    snap_q.push_back({32'h33, 32'h22, 32'h11});
    s0 = snap_cnt; r0 = rsp_cnt;
    poll_enable = 1'b1;
    n = 0;
    while (snap_cnt == s0 && n < 200) begin @(negedge reg_clk); n++; end
    poll_enable = 1'b0;
    check("scan_done", snap_cnt, s0 + 1);
    repeat (30) @(negedge reg_clk);
    check("scan_snap_once", snap_cnt, s0 + 1);
    check("scan_no_rsp", rsp_cnt, r0);
    check("scan_reads", rd_cycles, 12);
    for (int i = 0; i < 3; i++) begin
      check("scan_addr", addr_q[i], 14'(32'h400 + i));
      check("scan_hold", hi_q[i], 4);
    end
    check("scan_gap1", lo_q[1], 3);
    check("scan_gap2", lo_q[2], 3);
    check("scan_in_snap", in_snap, {32'h33, 32'h22, 32'h11});

    // Command raised on the cycle poll_due sets
    clr();
    s0 = snap_cnt;
    snap_q.push_back({32'h33, 32'h22, 32'h11});
    poll_enable = 1'b1;
    repeat (PD) @(negedge reg_clk);
    cmd_write = 1'b0; cmd_addr = 14'h401; cmd_valid = 1'b1;
    check("arb_ready_blocked", cmd_ready, 0);
    @(negedge reg_clk);
    check("arb_scan_first", {chip_sel, read_reg, busaddress}, {2'b11, 14'h400});
    poll_enable = 1'b0;
    send_cmd(1'b0, 14'h401, 32'h0, 32'h22, 1'b0, n);
    check("arb_cmd_wait", n + 1, 21);
    check("arb_snap_before_cmd", snap_cnt, s0 + 1);
    repeat (8) @(negedge reg_clk);
    check("arb_cmd_addr", addr_q[3], 14'h401);

    // Reset during the second scan word
    clr();
    s0 = snap_cnt; r0 = rsp_cnt;
    poll_enable = 1'b1;
    n = 0;
    while (!(chip_sel && busaddress == 14'h401) && n < 300) begin @(negedge reg_clk); n++; end
    check("rst_mid_found", chip_sel, 1);
    #2 reset_in = 1'b1;
    #1;
    check("rst_mid_strobes", {chip_sel, read_reg, write_reg}, 0);
    check("rst_mid_snap", in_snap, 0);
    poll_enable = 1'b0;
    repeat (2) @(negedge reg_clk);
    reset_in = 1'b0;
    clr();
    send_cmd(1'b1, 14'h441, 32'h5A, 32'h0, 1'b0, n);
    repeat (9) @(negedge reg_clk);
    check("rst_mid_no_snap", snap_cnt, s0);
    check("post_rst_write_cycles", wr_cycles, 4);
    check("post_rst_data", wd_q[0], 32'h5A);
    check("post_rst_rsp", rsp_cnt, r0 + 1);

    // Three back-to-back writes with cmd_valid held
    clr();
    r0 = rsp_cnt;
    send_cmd(1'b1, 14'h442, 32'h1, 32'h0, 1'b1, n);
    send_cmd(1'b1, 14'h443, 32'h2, 32'h0, 1'b1, n);
    send_cmd(1'b1, 14'h444, 32'h3, 32'h0, 1'b0, n);
    repeat (10) @(negedge reg_clk);
    check("b2b_rsp", rsp_cnt, r0 + 3);
    check("b2b_write_cycles", wr_cycles, 12);
    check("b2b_gap_count", lo_q.size(), 3);
    check("b2b_gap1", lo_q[1], 3);
    check("b2b_gap2", lo_q[2], 3);
    check("b2b_last_data", wd_q[2], 32'h3);

    check("rsp_pending", rsp_q.size(), 0);
    check("snap_pending", snap_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
